// File: rtl/sobel_frame_ctrl_if.sv
// Signal bundle between the capture side, the Sobel detector and sobel_frame_ctrl.
// The master drives config, capture and detector-output streams; the slave is the controller.
interface sobel_frame_ctrl_if #(
  parameter int unsigned CNT_W = 20,
  parameter int unsigned H_W   = 12,
  parameter int unsigned V_W   = 11
);
  logic             cfg_wr;
  logic             cfg_enable;
  logic             cfg_auto;
  logic [7:0]       cfg_thresh;
  logic [CNT_W-1:0] cfg_lo;
  logic [CNT_W-1:0] cfg_hi;
  logic             in_vsync;
  logic             in_href;
  logic             in_clken;
  logic             det_vsync;
  logic             det_href;
  logic             det_clken;
  logic [7:0]       thresh_o;
  logic             edge_vsync;
  logic             edge_href;
  logic             edge_clken;
  logic             edge_bit;
  logic             frame_done;
  logic [CNT_W-1:0] stat_edges;
  logic [H_W-1:0]   stat_width;
  logic [V_W-1:0]   stat_height;
  logic             stat_geom_err;

  modport master (
    output cfg_wr, cfg_enable, cfg_auto, cfg_thresh, cfg_lo, cfg_hi,
    output in_vsync, in_href, in_clken,
    output edge_vsync, edge_href, edge_clken, edge_bit,
    input  det_vsync, det_href, det_clken, thresh_o,
    input  frame_done, stat_edges, stat_width, stat_height, stat_geom_err
  );

  modport slave (
    input  cfg_wr, cfg_enable, cfg_auto, cfg_thresh, cfg_lo, cfg_hi,
    input  in_vsync, in_href, in_clken,
    input  edge_vsync, edge_href, edge_clken, edge_bit,
    output det_vsync, det_href, det_clken, thresh_o,
    output frame_done, stat_edges, stat_width, stat_height, stat_geom_err
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Per-frame Sobel controller: commits config at input frame start, gates the detector
// stream, captures input geometry, counts edge pixels and steps the threshold in auto mode.
module sobel_frame_ctrl #(
  parameter int unsigned THRESH_DEF = 35,
  parameter int unsigned STEP       = 2,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned H_W        = 12,
  parameter int unsigned V_W        = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  sobel_frame_ctrl_if.slave ctrl
);
  localparam logic [7:0]       THR_RST = 8'(THRESH_DEF);
  localparam logic [8:0]       STEP9   = 9'(STEP);
  localparam logic [H_W-1:0]   H_MAX   = '1;
  localparam logic [V_W-1:0]   V_MAX   = '1;
  localparam logic [CNT_W-1:0] E_MAX   = '1;

  logic             in_vs_q, in_href_q, in_clken_q, edge_vs_q;
  logic             sh_en_q, sh_en_d, sh_auto_q, sh_auto_d, dirty_q, dirty_d;
  logic [7:0]       sh_thr_q, sh_thr_d;
  logic [CNT_W-1:0] sh_lo_q, sh_lo_d, sh_hi_q, sh_hi_d;
  logic             en_q, en_d, auto_q, auto_d;
  logic [CNT_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [7:0]       thr_q, thr_d, auto_next_q, auto_next_d;
  logic [H_W-1:0]   h_cnt_q, h_cnt_d, ref_w_q, ref_w_d, st_w_q, st_w_d;
  logic [V_W-1:0]   v_cnt_q, v_cnt_d, st_h_q, st_h_d;
  logic             first_q, first_d, gerr_q, gerr_d, st_gerr_q, st_gerr_d;
  logic [CNT_W-1:0] e_cnt_q, e_cnt_d, st_e_q, st_e_d;
  logic             fdone_q, fdone_d;

  logic       ib, eb, pix, epix, href_fall;
  logic [8:0] up9, dn9;
  logic [7:0] thr_up, thr_dn;

  always_comb begin
    ib        = ctrl.in_vsync & ~in_vs_q;
    eb        = ctrl.edge_vsync & ~edge_vs_q;
    pix       = ctrl.in_href & ctrl.in_clken;
    epix      = ctrl.edge_href & ctrl.edge_clken & ctrl.edge_bit;
    href_fall = in_href_q & ~ctrl.in_href;
    up9       = {1'b0, thr_q} + STEP9;
    dn9       = {1'b0, thr_q} - STEP9;
    thr_up    = (up9 > 9'd255) ? 8'hFF : up9[7:0];
    thr_dn    = ({1'b0, thr_q} <= STEP9) ? 8'd1 : dn9[7:0];
  end

  always_comb begin
    sh_en_d     = sh_en_q;
    sh_auto_d   = sh_auto_q;
    sh_thr_d    = sh_thr_q;
    sh_lo_d     = sh_lo_q;
    sh_hi_d     = sh_hi_q;
    dirty_d     = dirty_q;
    en_d        = en_q;
    auto_d      = auto_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    thr_d       = thr_q;
    auto_next_d = auto_next_q;
    if (ib) begin
      en_d   = sh_en_q;
      auto_d = sh_auto_q;
      lo_d   = sh_lo_q;
      hi_d   = sh_hi_q;
      dirty_d = 1'b0;
      // A manual load also reseeds auto_next so a stale auto result never overrides it.
      if (dirty_q) begin
        thr_d       = sh_thr_q;
        auto_next_d = sh_thr_q;
      end else if (auto_q) begin
        thr_d = auto_next_q;
      end
    end
    if (ctrl.cfg_wr) begin
      sh_en_d   = ctrl.cfg_enable;
      sh_auto_d = ctrl.cfg_auto;
      sh_thr_d  = ctrl.cfg_thresh;
      sh_lo_d   = ctrl.cfg_lo;
      sh_hi_d   = ctrl.cfg_hi;
      dirty_d   = 1'b1;
    end
    if (eb && en_q && auto_q) begin
      if (e_cnt_q > hi_q)      auto_next_d = thr_up;
      else if (e_cnt_q < lo_q) auto_next_d = thr_dn;
      else                     auto_next_d = thr_q;
    end
  end

  always_comb begin
    h_cnt_d   = h_cnt_q;
    ref_w_d   = ref_w_q;
    v_cnt_d   = v_cnt_q;
    first_d   = first_q;
    gerr_d    = gerr_q;
    st_w_d    = st_w_q;
    st_h_d    = st_h_q;
    st_gerr_d = st_gerr_q;
    if (pix && h_cnt_q != H_MAX) h_cnt_d = h_cnt_q + 1'b1;
    if (href_fall) begin
      if (first_q) begin
        ref_w_d = h_cnt_q;
        first_d = 1'b0;
      end else if (h_cnt_q != ref_w_q) begin
        gerr_d = 1'b1;
      end
      if (v_cnt_q != V_MAX) v_cnt_d = v_cnt_q + 1'b1;
      h_cnt_d = '0;
    end
    if (ib) begin
      st_w_d    = ref_w_q;
      st_h_d    = v_cnt_q;
      st_gerr_d = gerr_q;
      ref_w_d   = '0;
      v_cnt_d   = '0;
      gerr_d    = 1'b0;
      first_d   = 1'b1;
    end
  end

  always_comb begin
    e_cnt_d = e_cnt_q;
    st_e_d  = st_e_q;
    fdone_d = 1'b0;
    // A pixel coincident with the boundary belongs to the new frame.
    if (eb) begin
      st_e_d  = e_cnt_q;
      e_cnt_d = epix ? CNT_W'(1) : '0;
      fdone_d = 1'b1;
    end else if (epix && e_cnt_q != E_MAX) begin
      e_cnt_d = e_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vs_q <= 1'b0;  in_href_q <= 1'b0;  in_clken_q <= 1'b0;  edge_vs_q <= 1'b0;
      sh_en_q <= 1'b1;  sh_auto_q <= 1'b0;  sh_thr_q <= THR_RST;
      sh_lo_q <= '0;    sh_hi_q <= '1;      dirty_q <= 1'b0;
      en_q <= 1'b1;     auto_q <= 1'b0;     lo_q <= '0;  hi_q <= '1;
      thr_q <= THR_RST; auto_next_q <= THR_RST;
      h_cnt_q <= '0;    ref_w_q <= '0;      v_cnt_q <= '0;
      first_q <= 1'b1;  gerr_q <= 1'b0;
      st_w_q <= '0;     st_h_q <= '0;       st_gerr_q <= 1'b0;
      e_cnt_q <= '0;    st_e_q <= '0;       fdone_q <= 1'b0;
    end else begin
      in_vs_q <= ctrl.in_vsync;  in_href_q <= ctrl.in_href;
      in_clken_q <= ctrl.in_clken;  edge_vs_q <= ctrl.edge_vsync;
      sh_en_q <= sh_en_d;  sh_auto_q <= sh_auto_d;  sh_thr_q <= sh_thr_d;
      sh_lo_q <= sh_lo_d;  sh_hi_q <= sh_hi_d;      dirty_q <= dirty_d;
      en_q <= en_d;  auto_q <= auto_d;  lo_q <= lo_d;  hi_q <= hi_d;
      thr_q <= thr_d;  auto_next_q <= auto_next_d;
      h_cnt_q <= h_cnt_d;  ref_w_q <= ref_w_d;  v_cnt_q <= v_cnt_d;
      first_q <= first_d;  gerr_q <= gerr_d;
      st_w_q <= st_w_d;  st_h_q <= st_h_d;  st_gerr_q <= st_gerr_d;
      e_cnt_q <= e_cnt_d;  st_e_q <= st_e_d;  fdone_q <= fdone_d;
    end
  end

  assign ctrl.det_vsync     = in_vs_q;
  assign ctrl.det_href      = in_href_q & en_q;
  assign ctrl.det_clken     = in_clken_q & en_q;
  assign ctrl.thresh_o      = thr_q;
  assign ctrl.frame_done    = fdone_q;
  assign ctrl.stat_edges    = st_e_q;
  assign ctrl.stat_width    = st_w_q;
  assign ctrl.stat_height   = st_h_q;
  assign ctrl.stat_geom_err = st_gerr_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: frames are driven back to back, expectations hand-computed.
module tb_sobel_frame_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_frame_ctrl_if ifc ();
  sobel_frame_ctrl dut (.clk(clk), .rst_n(rst_n), .ctrl(ifc));

  int   total = 0;
  int   bad = 0;
  int   lag_err, dh_cnt, dv_cnt, fd_cnt;
  logic en_exp = 1'b1;
  logic pv_vs, pv_hr, pv_ck;

  // One clock; records det_* lag errors against en_exp and counts output activity.
  task automatic step();
    pv_vs = ifc.in_vsync;
    pv_hr = ifc.in_href;
    pv_ck = ifc.in_clken;
    @(posedge clk);
    #1;
    if (ifc.det_vsync !== pv_vs || ifc.det_href !== (pv_hr & en_exp) ||
        ifc.det_clken !== (pv_ck & en_exp)) lag_err++;
    if (ifc.det_href === 1'b1) dh_cnt++;
    if (ifc.det_vsync === 1'b1) dv_cnt++;
    if (ifc.frame_done === 1'b1) fd_cnt++;
  endtask

  // cfg_ln = line after which cfg_wr pulses; -2 pulses it on the input-boundary cycle.
  task automatic run_frame(input int w, input int h, input int short_ln, input int n_edges,
                           input int cfg_ln, input bit eb_pix);
    int ec;
    ec = 0;
    lag_err = 0; dh_cnt = 0; dv_cnt = 0; fd_cnt = 0;
    ifc.in_vsync = 1'b1;
    if (cfg_ln == -2) ifc.cfg_wr = 1'b1;
    step();
    ifc.cfg_wr = 1'b0;
    step();
    ifc.in_vsync = 1'b0;
    ifc.edge_vsync = 1'b1;
    if (eb_pix) begin
      ifc.edge_href = 1'b1; ifc.edge_clken = 1'b1; ifc.edge_bit = 1'b1;
    end
    step();
    ifc.edge_href = 1'b0; ifc.edge_clken = 1'b0; ifc.edge_bit = 1'b0;
    step();
    ifc.edge_vsync = 1'b0;
    step();
    for (int l = 0; l < h; l++) begin
      int len;
      len = (l == short_ln) ? w - 1 : w;
      for (int p = 0; p < len; p++) begin
        ifc.in_href = 1'b1; ifc.in_clken = 1'b1;
        ifc.edge_href = 1'b1; ifc.edge_clken = 1'b1;
        ifc.edge_bit = (ec < n_edges);
        ec++;
        step();
      end
      ifc.in_href = 1'b0; ifc.in_clken = 1'b0;
      ifc.edge_href = 1'b0; ifc.edge_clken = 1'b0; ifc.edge_bit = 1'b0;
      if (l == cfg_ln) ifc.cfg_wr = 1'b1;
      step();
      ifc.cfg_wr = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    ifc.cfg_wr = 0; ifc.cfg_enable = 1; ifc.cfg_auto = 0; ifc.cfg_thresh = 8'd35;
    ifc.cfg_lo = '0; ifc.cfg_hi = '1;
    ifc.in_vsync = 0; ifc.in_href = 0; ifc.in_clken = 0;
    ifc.edge_vsync = 0; ifc.edge_href = 0; ifc.edge_clken = 0; ifc.edge_bit = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    total++; if (ifc.thresh_o !== 8'd35) begin bad++; $display("FAIL reset_thresh got=%0d exp=35", ifc.thresh_o); end
    total++; if ({ifc.det_vsync, ifc.det_href, ifc.det_clken} !== 3'b000) begin bad++; $display("FAIL reset_det got=%b exp=000", {ifc.det_vsync, ifc.det_href, ifc.det_clken}); end
    total++; if (ifc.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", ifc.frame_done); end
    total++; if (ifc.stat_edges !== '0 || ifc.stat_width !== '0 || ifc.stat_height !== '0 || ifc.stat_geom_err !== 1'b0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d/%0d/%b exp=0/0/0/0", ifc.stat_edges, ifc.stat_width, ifc.stat_height, ifc.stat_geom_err);
    end
  endtask

  task automatic test_geometry();
    en_exp = 1'b1;
    run_frame(64, 48, -1, 0, -1, 1'b0);
    total++; if (dh_cnt != 3072 || lag_err != 0) begin bad++; $display("FAIL geo_pass got=%0d/%0d exp=3072/0", dh_cnt, lag_err); end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL geo_frame_done got=%0d exp=1", fd_cnt); end
    for (int f = 0; f < 2; f++) begin
      run_frame(64, 48, -1, 0, -1, 1'b0);
      total++; if (ifc.stat_width !== 12'd64 || ifc.stat_height !== 11'd48 || ifc.stat_geom_err !== 1'b0) begin
        bad++; $display("FAIL geo_stats got=%0d/%0d/%b exp=64/48/0", ifc.stat_width, ifc.stat_height, ifc.stat_geom_err);
      end
      total++; if (lag_err != 0 || dv_cnt != 2) begin bad++; $display("FAIL geo_lag got=%0d/%0d exp=0/2", lag_err, dv_cnt); end
    end
  endtask

  task automatic test_geom_err();
    run_frame(32, 16, 3, 0, -1, 1'b0);
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (ifc.stat_geom_err !== 1'b1 || ifc.stat_width !== 12'd32 || ifc.stat_height !== 11'd16) begin
      bad++; $display("FAIL geom_err_set got=%b/%0d/%0d exp=1/32/16", ifc.stat_geom_err, ifc.stat_width, ifc.stat_height);
    end
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (ifc.stat_geom_err !== 1'b0) begin bad++; $display("FAIL geom_err_clear got=%b exp=0", ifc.stat_geom_err); end
  endtask

  task automatic test_enable_gate();
    ifc.cfg_enable = 0; ifc.cfg_auto = 0; ifc.cfg_thresh = 8'd35;
    en_exp = 1'b1;
    run_frame(32, 16, -1, 0, 4, 1'b0);
    total++; if (dh_cnt != 512 || lag_err != 0) begin bad++; $display("FAIL gate_cur_frame got=%0d/%0d exp=512/0", dh_cnt, lag_err); end
    en_exp = 1'b0;
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (dh_cnt != 0 || lag_err != 0) begin bad++; $display("FAIL gate_off got=%0d/%0d exp=0/0", dh_cnt, lag_err); end
    total++; if (dv_cnt != 2) begin bad++; $display("FAIL gate_vsync got=%0d exp=2", dv_cnt); end
  endtask

  task automatic test_thresh_commit();
    ifc.cfg_enable = 1; ifc.cfg_thresh = 8'd80;
    run_frame(32, 16, -1, 0, 2, 1'b0);
    total++; if (ifc.thresh_o !== 8'd35) begin bad++; $display("FAIL thr_hold got=%0d exp=35", ifc.thresh_o); end
    en_exp = 1'b1;
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd80) begin bad++; $display("FAIL thr_commit got=%0d exp=80", ifc.thresh_o); end
    total++; if (dh_cnt != 512) begin bad++; $display("FAIL reenable got=%0d exp=512", dh_cnt); end
    ifc.cfg_thresh = 8'd90;
    run_frame(32, 16, -1, 0, -2, 1'b0);
    total++; if (ifc.thresh_o !== 8'd80) begin bad++; $display("FAIL thr_wr_at_ib got=%0d exp=80", ifc.thresh_o); end
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd90) begin bad++; $display("FAIL thr_wr_pending got=%0d exp=90", ifc.thresh_o); end
  endtask

  task automatic test_auto_up();
    logic [7:0] exp_thr[5];
    exp_thr[0] = 8'd40; exp_thr[1] = 8'd40; exp_thr[2] = 8'd42; exp_thr[3] = 8'd44; exp_thr[4] = 8'd254;
    ifc.cfg_enable = 1; ifc.cfg_auto = 1; ifc.cfg_thresh = 8'd40; ifc.cfg_lo = '0; ifc.cfg_hi = 20'd100;
    run_frame(32, 16, -1, 0, 1, 1'b0);
    for (int f = 0; f < 5; f++) begin
      if (f == 3) ifc.cfg_thresh = 8'd254;
      run_frame(32, 16, -1, 500, (f == 3) ? 1 : -1, 1'b0);
      total++; if (ifc.thresh_o !== exp_thr[f]) begin bad++; $display("FAIL auto_up_f%0d got=%0d exp=%0d", f, ifc.thresh_o, exp_thr[f]); end
    end
    total++; if (ifc.stat_edges !== 20'd500 || fd_cnt != 1) begin bad++; $display("FAIL auto_edges got=%0d/%0d exp=500/1", ifc.stat_edges, fd_cnt); end
    run_frame(32, 16, -1, 500, -1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd255) begin bad++; $display("FAIL auto_clamp_hi got=%0d exp=255", ifc.thresh_o); end
    ifc.cfg_thresh = 8'd2; ifc.cfg_lo = 20'd10; ifc.cfg_hi = '1;
    run_frame(32, 16, -1, 0, 1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd255) begin bad++; $display("FAIL auto_clamp_stay got=%0d exp=255", ifc.thresh_o); end
  endtask

  task automatic test_auto_down();
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd2 || ifc.stat_edges !== '0) begin bad++; $display("FAIL auto_dn_load got=%0d/%0d exp=2/0", ifc.thresh_o, ifc.stat_edges); end
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd1) begin bad++; $display("FAIL auto_dn_step got=%0d exp=1", ifc.thresh_o); end
    ifc.cfg_enable = 0; ifc.cfg_thresh = 8'd50;
    run_frame(32, 16, -1, 0, 1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd1) begin bad++; $display("FAIL auto_dn_floor got=%0d exp=1", ifc.thresh_o); end
    en_exp = 1'b0;
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd50 || dh_cnt != 0) begin bad++; $display("FAIL auto_dis_load got=%0d/%0d exp=50/0", ifc.thresh_o, dh_cnt); end
    run_frame(32, 16, -1, 0, -1, 1'b0);
    total++; if (ifc.thresh_o !== 8'd50) begin bad++; $display("FAIL auto_dis_hold got=%0d exp=50", ifc.thresh_o); end
  endtask

  task automatic test_edge_boundary();
    run_frame(8, 4, -1, 5, -1, 1'b1);
    run_frame(8, 4, -1, 0, -1, 1'b0);
    total++; if (ifc.stat_edges !== 20'd6) begin bad++; $display("FAIL eb_pixel got=%0d exp=6", ifc.stat_edges); end
    total++; if (ifc.stat_width !== 12'd8 || ifc.stat_height !== 11'd4) begin bad++; $display("FAIL small_geo got=%0d/%0d exp=8/4", ifc.stat_width, ifc.stat_height); end
  endtask

  task automatic test_reset_mid();
    ifc.in_href = 1'b1; ifc.in_clken = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (ifc.thresh_o !== 8'd35 || ifc.stat_width !== '0 || ifc.stat_edges !== '0) begin
      bad++; $display("FAIL mid_reset got=%0d/%0d/%0d exp=35/0/0", ifc.thresh_o, ifc.stat_width, ifc.stat_edges);
    end
    #2 rst_n = 1'b1;
    en_exp = 1'b1;
    step();
    total++; if (ifc.det_href !== 1'b1 || ifc.det_clken !== 1'b1) begin bad++; $display("FAIL mid_reset_resume got=%b%b exp=11", ifc.det_href, ifc.det_clken); end
    ifc.in_href = 1'b0; ifc.in_clken = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_geom_err();
    test_enable_gate();
    test_thresh_commit();
    test_auto_up();
    test_auto_down();
    test_edge_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
